// File: rtl/pipeline_fwd.sv
// Three-stage execute pipeline (S1 decode/read, S2 ALU, S3 writeback) with stall and register file.
// Define PIPE_FWD_EN to enable S2/S3 -> S1 operand forwarding; otherwise S1 always reads the register file.
module pipeline_fwd #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_in,
  input  logic              in_valid,
  input  logic              stall,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_we
);

  localparam int DEPTH = 2 ** ADDR_W;

  // S1: decoded instruction
  logic              s1_valid, s1_src, s1_we;
  logic [2:0]        s1_op;
  logic [ADDR_W-1:0] s1_rd, s1_rs1, s1_rs2;
  logic [WIDTH-1:0]  s1_imm;

  // S2: resolved operands
  logic              s2_valid, s2_we;
  logic [2:0]        s2_op;
  logic [ADDR_W-1:0] s2_rd;
  logic [WIDTH-1:0]  s2_a, s2_b;

  // S3: result
  logic              s3_valid, s3_we;
  logic [ADDR_W-1:0] s3_rd;
  logic [WIDTH-1:0]  s3_res;

  logic [WIDTH-1:0]  rf [DEPTH];
  logic [WIDTH-1:0]  rf_a, rf_b, op_a, rs2_val, op_b, alu_res;
  logic [4:0]        shamt;

  logic unused_bits;
  assign unused_bits = instr_in[26];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_src   <= 1'b0;
      s1_we    <= 1'b0;
      s1_op    <= '0;
      s1_rd    <= '0;
      s1_rs1   <= '0;
      s1_rs2   <= '0;
      s1_imm   <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_op    <= instr_in[31:29];
      s1_src   <= instr_in[28];
      s1_we    <= instr_in[27];
      s1_rd    <= instr_in[21 +: ADDR_W];
      s1_rs1   <= instr_in[16 +: ADDR_W];
      s1_rs2   <= instr_in[11 +: ADDR_W];
      s1_imm   <= WIDTH'($signed(instr_in[15:0]));
    end
  end

  // Register 0 is never written, but the explicit guard keeps it reading 0 regardless.
  assign rf_a = (s1_rs1 == '0) ? '0 : rf[s1_rs1];
  assign rf_b = (s1_rs2 == '0) ? '0 : rf[s1_rs2];

`ifdef PIPE_FWD_EN
  logic s2_fwd_ok, s3_fwd_ok;
  assign s2_fwd_ok = s2_valid && s2_we;
  assign s3_fwd_ok = s3_valid && s3_we;

  always_comb begin
    op_a = rf_a;
    if (s1_rs1 != '0 && s2_fwd_ok && s2_rd == s1_rs1)      op_a = alu_res;
    else if (s1_rs1 != '0 && s3_fwd_ok && s3_rd == s1_rs1) op_a = s3_res;
    rs2_val = rf_b;
    if (s1_rs2 != '0 && s2_fwd_ok && s2_rd == s1_rs2)      rs2_val = alu_res;
    else if (s1_rs2 != '0 && s3_fwd_ok && s3_rd == s1_rs2) rs2_val = s3_res;
  end
`else
  assign op_a    = rf_a;
  assign rs2_val = rf_b;
`endif

  assign op_b = s1_src ? s1_imm : rs2_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_we    <= 1'b0;
      s2_op    <= '0;
      s2_rd    <= '0;
      s2_a     <= '0;
      s2_b     <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      s2_we    <= s1_we;
      s2_op    <= s1_op;
      s2_rd    <= s1_rd;
      s2_a     <= op_a;
      s2_b     <= op_b;
    end
  end

  // Shifts past the datapath width naturally yield 0 for narrow WIDTH.
  assign shamt = s2_b[4:0];

  always_comb begin
    alu_res = '0;
    unique case (s2_op)
      3'b000: alu_res = s2_a + s2_b;
      3'b001: alu_res = s2_a - s2_b;
      3'b010: alu_res = s2_a & s2_b;
      3'b011: alu_res = s2_a | s2_b;
      3'b100: alu_res = s2_a ^ s2_b;
      3'b101: alu_res = s2_a << shamt;
      3'b110: alu_res = s2_a >> shamt;
      3'b111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(s2_a) < $signed(s2_b))};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s3_valid <= 1'b0;
      s3_we    <= 1'b0;
      s3_rd    <= '0;
      s3_res   <= '0;
    end else if (!stall) begin
      s3_valid <= s2_valid;
      s3_we    <= s2_we;
      s3_rd    <= s2_rd;
      s3_res   <= alu_res;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (!stall && out_we && s3_rd != '0) begin
      rf[s3_rd] <= s3_res;
    end
  end

  assign out       = s3_res;
  assign out_valid = s3_valid;
  assign out_rd    = s3_rd;
  assign out_we    = s3_valid && s3_we;

endmodule

// File: doc/pipeline_fwd.md
# pipeline_fwd

Parametrised three-stage execute pipeline: decode/read (S1), ALU (S2), writeback (S3), with per-stage valid bits, a global stall, immediate sign-extension and operand forwarding from S2/S3 into S1. It generalises the fixed 32-bit datapath in datapath width and register-file depth. It sits between the instruction source and any result consumer, and owns its register file.

## Interface
- `WIDTH`, default 32: datapath and register width; must be ≥16.
- `ADDR_W`, default 5: register index width, range 1..5; the register file has 2^ADDR_W entries.
- `clk` in, 1 bit: single clock; all state changes on the rising edge.
- `reset` in, 1 bit: asynchronous, active-low. Low clears all state immediately.
- `instr_in` in, 32 bits: instruction word, sampled when `in_valid`=1 and `stall`=0.
- `in_valid` in, 1 bit: `instr_in` holds a real instruction; 0 inserts a bubble.
- `stall` in, 1 bit: freezes every pipeline register and blocks register-file writes.
- `out` out, WIDTH bits: S3 result.
- `out_valid` out, 1 bit: S3 holds a real instruction.
- `out_rd` out, ADDR_W bits: S3 destination register.
- `out_we` out, 1 bit: S3 write enable, qualified by `out_valid`.

## Operation
- Instruction fields:
  - [31:29] alu_op; [28] src (1 = immediate); [27] we; [26] reserved, ignored.
  - [25:21] rd; [20:16] rs1; [15:11] rs2; [15:0] imm16.
  - Register fields use their low ADDR_W bits.
- imm16 is sign-extended to WIDTH. Operand a = rs1 value; operand b = src ? imm : rs2 value.
- ALU ops on a,b:
  - 000 add, 001 sub (a−b), 010 and, 011 or, 100 xor.
  - 101 sll a by b[4:0], 110 srl (logical) a by b[4:0].
  - 111 slt signed: result 1 if a<b, else 0. Shift amounts ≥WIDTH give 0.
- Arithmetic wraps modulo 2^WIDTH. No flags.
- Register 0 reads as 0 always. Writes to it are discarded, and it is never a forwarding source.
- Register-file read is combinational with no internal write-through. A write occurs on an edge where S3 is valid, `out_we`=1 and `stall`=0.
- Forwarding, applied per source operand in S1:
  - Source index ≠0 and matches the valid, we=1 S2 entry: take the ALU result.
  - Else matches the valid, we=1 S3 entry: take `out`.
  - Else take the register-file value. S2 has priority over S3.
- Bubbles (valid=0) never write and never forward. Their data fields may hold any value, but `out_valid`/`out_we` are 0.

## Timing
- Instruction accepted at edge N:
  - S1 is valid after edge N.
  - S2 captures the forwarded operands at edge N+1.
  - `out`/`out_valid` become valid after edge N+2.
  - The register-file write occurs at edge N+3.
  - Latency to `out` is 2 cycles after acceptance.
- Back-to-back dependent instructions at distance 1, 2 or ≥3 all see the correct value. No hazard stalls are generated internally.
- `stall`=1 at an edge: no stage advances, no write, inputs are ignored, and outputs hold. Forwarding is recomputed combinationally each cycle, so a stalled S1 sees current S2/S3.
- `in_valid`=0 with `stall`=0: S1 becomes a bubble.
- Reset low, asynchronous, at any point including mid-stream:
  - `out`=0, `out_valid`=0, `out_rd`=0, `out_we`=0.
  - All stage valids = 0; all registers = 0.
  - In-flight instructions are discarded.
- First acceptance possible at the first rising edge after `reset` rises.

## Configuration
- `PIPE_FWD_EN` defined: forwarding as described above.
- `PIPE_FWD_EN` undefined: the forwarding muxes are removed and S1 always reads the register file.
  - A consumer at distance 1 or 2 from its producer receives the stale pre-write value.
  - At distance ≥3 it is correct. All other behaviour is identical.

## Test plan
- Reset, then issue addi r1,r0,5 (op 000, src 1, we 1, imm 5) -> `out`=5, `out_valid`=1, `out_rd`=1 two cycles after acceptance; r1=5 after the following edge.
- addi r1,r0,7; then next cycle add r2,r1,r1 -> second `out`=14 with forwarding. Without `PIPE_FWD_EN` the result is 0.
- addi r3,r0,−1 (imm 0xFFFF); sub r4,r0,r3; slt r5,r3,r0 -> `out` = all-ones, then 1, then 1.
- Issue an instruction, hold `stall`=1 for 3 cycles -> outputs frozen, no write, no duplicate `out_valid` pulse; the pipeline resumes with correct order.
- addi r0,r0,9, then add r6,r0,r0 -> r0 stays 0 and `out`=0 for the second instruction.
- Assert `reset` low mid-stream with 3 instructions in flight -> all outputs 0 immediately; register r1 reads 0 afterwards.
